mem_shadow_ctrl: RTL and testbench
==================================

MEM_SHADOW_CTRL -- requirements
Module: mem_shadow_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, word-address width of the shadow port.
REQ-002 Parameter DATA_W, default 32, shadow word width.
REQ-003 Parameter DEPTH, default 256, number of words; legal range 1..2^ADDR_W inclusive.
REQ-004 Parameter AUTO_PRELOAD, default 1, run a preload automatically after reset release.
REQ-005 clk_i  in  1  sole clock; all logic on the rising edge.
REQ-006 rst_ni  in  1  asynchronous, active-low reset.
REQ-007 req_valid_i / req_ready_o  in/out  1  host request handshake.
REQ-008 req_op_i  in  2  0=read, 1=write, 2=preload, 3=illegal.
REQ-009 req_addr_i  in  ADDR_W  word address; req_wdata_i  in  DATA_W  write data.
REQ-010 rsp_valid_o / rsp_ready_i  out/in  1  response handshake.
REQ-011 rsp_rdata_o  out  DATA_W  read data, 0 for non-read ops; rsp_err_o  out  1  error flag.
REQ-012 shadow_addr_o  out  ADDR_W, shadow_wdata_o  out  DATA_W, shadow_we_o  out  1, shadow_re_o  out  1: memory shadow port.
REQ-013 shadow_rdata_i  in  DATA_W  valid the cycle after shadow_re_o.
REQ-014 init_addr_o  out  ADDR_W, init_rdata_i  in  DATA_W: initial-image ROM, data valid the cycle after the address.
REQ-015 busy_o  out  1  any non-IDLE state; preload_done_o  out  1  sticky preload-complete flag.

Function
REQ-016 States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP, PL_RUN, PL_LAST.
REQ-017 req_ready_o = 1 only in IDLE with no response pending; the transfer occurs on req_valid_i & req_ready_o (cycle t).
REQ-018 A read with addr < DEPTH: t+1 RD_ISSUE, shadow_re_o=1, shadow_addr_o=addr. t+2 RD_WAIT, shadow_rdata_i captured. t+3 onward RESP, rsp_valid_o=1, err=0.
REQ-019 A write with addr < DEPTH: t+1 WR_ISSUE, shadow_we_o=1, addr and data driven. t+2 onward RESP, rdata=0, err=0.
REQ-020 Read/write with addr >= DEPTH, and op 3, cause no shadow access; RESP from t+1 with err=1, rdata=0.
REQ-021 The DEPTH bound compare is performed at ADDR_W+1 bits, so DEPTH=2^ADDR_W accepts every address and never wraps to reject-all.
REQ-022 In RESP, rsp_valid_o holds with stable rdata/err until rsp_ready_i; the cycle after the handshake the state is IDLE.
REQ-023 Preload (op 2): preload_done_o clears at t+1 and PL_RUN is entered. Cycle k of PL_RUN drives init_addr_o=k for k=0..DEPTH-1. From the second PL_RUN cycle, shadow_we_o=1 with shadow_addr_o=k-1 and shadow_wdata_o=init_rdata_i.
REQ-024 The preload index counter is ADDR_W+1 bits. After init_addr_o=DEPTH-1, PL_LAST writes word DEPTH-1. The next state is RESP (err=0); preload_done_o sets in that same cycle.
REQ-025 A preload takes DEPTH+1 cycles of shadow/init activity, 1 word/cycle, with no bubbles.
REQ-026 shadow_we_o and shadow_re_o are never both 1 and are 0 outside the states named above.
REQ-027 Outputs not in use hold 0 (addresses, data, strobes).
REQ-028 An AUTO_PRELOAD preload runs identically but produces no response; it returns to IDLE after PL_LAST.
REQ-029 A preload_done_o that is already 1 stays 1 through reads and writes.

Reset
REQ-030 While rst_ni=0: state IDLE, all outputs 0, preload_done_o=0, captured data cleared. Any in-flight operation is abandoned with no response.
REQ-031 AUTO_PRELOAD=1: the first cycle after rst_ni rises enters PL_RUN and req_ready_o stays 0 until it finishes. AUTO_PRELOAD=0: the first cycle after rst_ni rises is IDLE.
REQ-032 Reset asserted mid-preload leaves preload_done_o=0. With AUTO_PRELOAD=1, the preload restarts from index 0 after release.

Verification
REQ-033 DEPTH=64, AUTO_PRELOAD=1, init ROM word i = 0xA0A00000+i -> 65 active cycles, shadow writes addr 0..63 with matching data, preload_done_o=1, then req_ready_o=1.
REQ-034 Write addr 5, data 0xBEEF0005, then read addr 5 with shadow model returning the written value -> write RESP at t+2 with err=0. Read: re at t+1, rsp_valid at t+3, rdata=0xBEEF0005.
REQ-035 ADDR_W=8, DEPTH=256: read addr 255 -> err=0, shadow access occurs. Preload -> final write addr 255, no early termination.
REQ-036 DEPTH=16: read addr 16, and op 3 -> RESP at t+1 with err=1, no shadow strobe.
REQ-037 Hold rsp_ready_i=0 for 10 cycles after a read -> rsp_valid_o and rdata stable, req_ready_o=0 throughout.
REQ-038 Assert rst_ni=0 at preload index 30, release -> all outputs 0 during reset, preload restarts at init_addr_o=0, preload_done_o=0 until complete.

Source files
------------

// File: rtl/mem_shadow_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_shadow_ctrl
// Purpose  : Host read/write controller for a shadow memory, with a streaming
//            preload of the whole array from an initial-image ROM.
// Revision : 1.0 - initial release
// ============================================================================
module mem_shadow_ctrl #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 256,
    parameter int AUTO_PRELOAD = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_op_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic [ADDR_W-1:0] shadow_addr_o,
    output logic [DATA_W-1:0] shadow_wdata_o,
    output logic              shadow_we_o,
    output logic              shadow_re_o,
    input  logic [DATA_W-1:0] shadow_rdata_i,
    output logic [ADDR_W-1:0] init_addr_o,
    input  logic [DATA_W-1:0] init_rdata_i,
    output logic              busy_o,
    output logic              preload_done_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_ISSUE = 3'd1,
        S_RD_WAIT  = 3'd2,
        S_WR_ISSUE = 3'd3,
        S_RESP     = 3'd4,
        S_PL_RUN   = 3'd5,
        S_PL_LAST  = 3'd6
    } state_t;

    localparam logic [1:0]      c_op_read    = 2'd0;
    localparam logic [1:0]      c_op_write   = 2'd1;
    localparam logic [1:0]      c_op_preload = 2'd2;
    // One extra bit so DEPTH = 2**ADDR_W is representable and never wraps to 0.
    localparam logic [ADDR_W:0] c_depth      = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] c_depth_m1   = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] c_one        = (ADDR_W+1)'(1);

    state_t              r_state;
    logic                r_req_ready;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;
    logic [ADDR_W-1:0]   r_shadow_addr;
    logic [DATA_W-1:0]   r_shadow_wdata;
    logic                r_shadow_we;
    logic                r_shadow_re;
    logic [ADDR_W:0]     r_pl_idx;
    logic                r_pl_rsp;
    logic                r_auto_pend;
    logic                r_preload_done;

    logic                w_in_range;
    logic                w_pl_wr;

    assign w_in_range = ({1'b0, req_addr_i} < c_depth);
    // ROM data arrives one cycle after its address, so it feeds the write port directly.
    assign w_pl_wr    = r_shadow_we && ((r_state == S_PL_RUN) || (r_state == S_PL_LAST));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state        <= S_IDLE;
            r_req_ready    <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_rdata    <= '0;
            r_rsp_err      <= 1'b0;
            r_shadow_addr  <= '0;
            r_shadow_wdata <= '0;
            r_shadow_we    <= 1'b0;
            r_shadow_re    <= 1'b0;
            r_pl_idx       <= '0;
            r_pl_rsp       <= 1'b0;
            r_auto_pend    <= (AUTO_PRELOAD != 0);
            r_preload_done <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_auto_pend) begin
                        r_auto_pend    <= 1'b0;
                        r_pl_rsp       <= 1'b0;
                        r_pl_idx       <= '0;
                        r_preload_done <= 1'b0;
                        r_req_ready    <= 1'b0;
                        r_state        <= S_PL_RUN;
                    end else if (req_valid_i && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        if (req_op_i == c_op_preload) begin
                            r_pl_rsp       <= 1'b1;
                            r_pl_idx       <= '0;
                            r_preload_done <= 1'b0;
                            r_state        <= S_PL_RUN;
                        end else if ((req_op_i == c_op_read) && w_in_range) begin
                            r_shadow_re   <= 1'b1;
                            r_shadow_addr <= req_addr_i;
                            r_state       <= S_RD_ISSUE;
                        end else if ((req_op_i == c_op_write) && w_in_range) begin
                            r_shadow_we    <= 1'b1;
                            r_shadow_addr  <= req_addr_i;
                            r_shadow_wdata <= req_wdata_i;
                            r_state        <= S_WR_ISSUE;
                        end else begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_rsp_err   <= 1'b1;
                            r_state     <= S_RESP;
                        end
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                S_RD_ISSUE: begin
                    r_shadow_re   <= 1'b0;
                    r_shadow_addr <= '0;
                    r_state       <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    r_rsp_rdata <= shadow_rdata_i;
                    r_rsp_err   <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_WR_ISSUE: begin
                    r_shadow_we    <= 1'b0;
                    r_shadow_addr  <= '0;
                    r_shadow_wdata <= '0;
                    r_rsp_rdata    <= '0;
                    r_rsp_err      <= 1'b0;
                    r_rsp_valid    <= 1'b1;
                    r_state        <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                S_PL_RUN: begin
                    r_shadow_we   <= 1'b1;
                    r_shadow_addr <= r_pl_idx[ADDR_W-1:0];
                    if (r_pl_idx == c_depth_m1) begin
                        r_pl_idx <= '0;
                        r_state  <= S_PL_LAST;
                    end else begin
                        r_pl_idx <= r_pl_idx + c_one;
                    end
                end
                S_PL_LAST: begin
                    r_shadow_we    <= 1'b0;
                    r_shadow_addr  <= '0;
                    r_preload_done <= 1'b1;
                    if (r_pl_rsp) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b0;
                        r_state     <= S_RESP;
                    end else begin
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o    = r_req_ready;
    assign rsp_valid_o    = r_rsp_valid;
    assign rsp_rdata_o    = r_rsp_rdata;
    assign rsp_err_o      = r_rsp_err;
    assign shadow_addr_o  = r_shadow_addr;
    assign shadow_wdata_o = w_pl_wr ? init_rdata_i : r_shadow_wdata;
    assign shadow_we_o    = r_shadow_we;
    assign shadow_re_o    = r_shadow_re;
    assign init_addr_o    = r_pl_idx[ADDR_W-1:0];
    assign busy_o         = (r_state != S_IDLE);
    assign preload_done_o = r_preload_done;

endmodule
`default_nettype wire

// File: tb/tb_mem_shadow_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_shadow_ctrl
// Purpose  : Directed scoreboard bench for mem_shadow_ctrl (two configurations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_shadow_ctrl;

    localparam int A_AW = 6;
    localparam int A_DEPTH = 64;
    localparam int B_AW = 8;
    localparam int B_DEPTH = 16;

    typedef struct packed { logic [7:0] addr; logic [31:0] data; } wr_t;
    typedef struct packed { logic [31:0] rdata; logic err; } rsp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic            a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [1:0]      a_req_op;
    logic [A_AW-1:0] a_req_addr, a_saddr, a_init_addr;
    logic [31:0]     a_req_wdata, a_rsp_rdata, a_swdata, a_srdata, a_init_rdata;
    logic            a_we, a_re, a_busy, a_done;

    logic            b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [1:0]      b_req_op;
    logic [B_AW-1:0] b_req_addr, b_saddr, b_init_addr;
    logic [31:0]     b_req_wdata, b_rsp_rdata, b_swdata, b_srdata, b_init_rdata;
    logic            b_we, b_re, b_busy, b_done;

    mem_shadow_ctrl #(.ADDR_W(A_AW), .DATA_W(32), .DEPTH(A_DEPTH), .AUTO_PRELOAD(1)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_op_i(a_req_op),
        .req_addr_i(a_req_addr), .req_wdata_i(a_req_wdata),
        .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready),
        .rsp_rdata_o(a_rsp_rdata), .rsp_err_o(a_rsp_err),
        .shadow_addr_o(a_saddr), .shadow_wdata_o(a_swdata), .shadow_we_o(a_we),
        .shadow_re_o(a_re), .shadow_rdata_i(a_srdata),
        .init_addr_o(a_init_addr), .init_rdata_i(a_init_rdata),
        .busy_o(a_busy), .preload_done_o(a_done)
    );

    mem_shadow_ctrl #(.ADDR_W(B_AW), .DATA_W(32), .DEPTH(B_DEPTH), .AUTO_PRELOAD(0)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_op_i(b_req_op),
        .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata),
        .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
        .rsp_rdata_o(b_rsp_rdata), .rsp_err_o(b_rsp_err),
        .shadow_addr_o(b_saddr), .shadow_wdata_o(b_swdata), .shadow_we_o(b_we),
        .shadow_re_o(b_re), .shadow_rdata_i(b_srdata),
        .init_addr_o(b_init_addr), .init_rdata_i(b_init_rdata),
        .busy_o(b_busy), .preload_done_o(b_done)
    );

    // Shadow memories and init ROMs: read data one cycle after the address.
    logic [31:0] a_mem [A_DEPTH];
    logic [31:0] b_mem [256];
    always @(posedge clk) begin
        if (a_we) a_mem[a_saddr] <= a_swdata;
        a_srdata     <= a_re ? a_mem[a_saddr] : 32'h0;
        a_init_rdata <= 32'hA0A0_0000 + 32'(a_init_addr);
        if (b_we) b_mem[b_saddr] <= b_swdata;
        b_srdata     <= b_re ? b_mem[b_saddr] : 32'h0;
        b_init_rdata <= 32'hC0DE_0000 + 32'(b_init_addr);
    end

    int n_chk = 0;
    int n_fail = 0;
    wr_t  a_wq [$];
    wr_t  b_wq [$];
    rsp_t a_rq [$];
    rsp_t b_rq [$];
    wr_t  a_wexp, b_wexp;
    rsp_t a_rexp, b_rexp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard pop side: shadow writes and response handshakes.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_we || a_re) chk("a_we_re_excl", 64'(a_we & a_re), 64'd0);
            if (a_we) begin
                chk("a_wr_expected", 64'(a_wq.size() != 0), 64'd1);
                if (a_wq.size() != 0) begin
                    a_wexp = a_wq.pop_front();
                    chk("a_wr_addr", 64'(a_saddr), 64'(a_wexp.addr));
                    chk("a_wr_data", 64'(a_swdata), 64'(a_wexp.data));
                end
            end
            if (a_rsp_valid && a_rsp_ready) begin
                chk("a_rsp_expected", 64'(a_rq.size() != 0), 64'd1);
                if (a_rq.size() != 0) begin
                    a_rexp = a_rq.pop_front();
                    chk("a_rsp_rdata", 64'(a_rsp_rdata), 64'(a_rexp.rdata));
                    chk("a_rsp_err", 64'(a_rsp_err), 64'(a_rexp.err));
                end
            end
            if (b_we) begin
                chk("b_wr_expected", 64'(b_wq.size() != 0), 64'd1);
                if (b_wq.size() != 0) begin
                    b_wexp = b_wq.pop_front();
                    chk("b_wr_addr", 64'(b_saddr), 64'(b_wexp.addr));
                    chk("b_wr_data", 64'(b_swdata), 64'(b_wexp.data));
                end
            end
            if (b_rsp_valid && b_rsp_ready) begin
                chk("b_rsp_expected", 64'(b_rq.size() != 0), 64'd1);
                if (b_rq.size() != 0) begin
                    b_rexp = b_rq.pop_front();
                    chk("b_rsp_rdata", 64'(b_rsp_rdata), 64'(b_rexp.rdata));
                    chk("b_rsp_err", 64'(b_rsp_err), 64'(b_rexp.err));
                end
            end
        end
    end

    task automatic chk_reset_outs(input string tag);
        chk(tag, 64'({a_req_ready, a_rsp_valid, a_rsp_err, a_we, a_re, a_busy, a_done,
                      |a_rsp_rdata, |a_saddr, |a_swdata, |a_init_addr,
                      b_req_ready, b_rsp_valid, b_busy, b_done, b_we, b_re, |b_init_addr}), 64'd0);
    endtask

    task automatic push_a_preload();
        for (int i = 0; i < A_DEPTH; i++) a_wq.push_back({8'(i), 32'hA0A0_0000 + 32'(i)});
    endtask

    // Returns at cycle t+1 of the request.
    task automatic a_send(input logic [1:0] op, input logic [A_AW-1:0] addr, input logic [31:0] wd);
        int w = 0;
        while (a_req_ready !== 1'b1 && w < 200) begin tick(); w++; end
        chk("a_ready_wait", 64'(a_req_ready), 64'd1);
        a_req_valid = 1'b1; a_req_op = op; a_req_addr = addr; a_req_wdata = wd;
        tick();
        a_req_valid = 1'b0; a_req_op = 2'd0; a_req_addr = '0; a_req_wdata = '0;
    endtask

    task automatic b_send(input logic [1:0] op, input logic [B_AW-1:0] addr, input logic [31:0] wd);
        int w = 0;
        while (b_req_ready !== 1'b1 && w < 200) begin tick(); w++; end
        chk("b_ready_wait", 64'(b_req_ready), 64'd1);
        b_req_valid = 1'b1; b_req_op = op; b_req_addr = addr; b_req_wdata = wd;
        tick();
        b_req_valid = 1'b0; b_req_op = 2'd0; b_req_addr = '0; b_req_wdata = '0;
    endtask

    // Called in the first PL_RUN cycle; walks the preload and checks its shape.
    task automatic a_run_preload(input bit exp_rsp);
        int n = 0;
        int bad = 0;
        while (a_busy && !a_rsp_valid && n < 300) begin
            if (n < A_DEPTH) begin
                if (a_init_addr !== A_AW'(n)) bad++;
            end else if (a_init_addr !== '0) bad++;
            if (a_done !== 1'b0 || a_req_ready !== 1'b0) bad++;
            n++;
            tick();
        end
        chk("pl_active_cycles", 64'(n), 64'(A_DEPTH + 1));
        chk("pl_sequence", 64'(bad), 64'd0);
        chk("pl_done_set", 64'(a_done), 64'd1);
        if (exp_rsp) begin
            chk("pl_rsp_valid", 64'(a_rsp_valid), 64'd1);
        end else begin
            chk("pl_auto_idle", 64'(a_busy), 64'd0);
            chk("pl_auto_ready", 64'(a_req_ready), 64'd1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        rst_n = 1'b0;
        a_req_valid = 1'b0; a_req_op = 2'd0; a_req_addr = '0; a_req_wdata = '0; a_rsp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_op = 2'd0; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 1'b1;
        repeat (3) tick();
        chk_reset_outs("reset_outputs");

        // Automatic preload after reset release.
        push_a_preload();
        rst_n = 1'b1;
        tick();
        chk("a_first_cycle_busy", 64'(a_busy), 64'd1);
        chk("b_first_cycle_idle", 64'(b_busy), 64'd0);
        chk("b_ready_after_reset", 64'(b_req_ready), 64'd1);
        a_run_preload(1'b0);

        // Write then read word 5.
        a_wq.push_back({8'd5, 32'hBEEF_0005});
        a_rq.push_back({32'h0, 1'b0});
        a_send(2'd1, 6'd5, 32'hBEEF_0005);
        chk("wr_t1_we", 64'(a_we), 64'd1);
        chk("wr_t1_ready_low", 64'(a_req_ready), 64'd0);
        tick();
        chk("wr_t2_rsp_valid", 64'(a_rsp_valid), 64'd1);
        tick();
        chk("wr_done_ready", 64'(a_req_ready), 64'd1);

        a_rq.push_back({32'hBEEF_0005, 1'b0});
        a_send(2'd0, 6'd5, 32'h0);
        chk("rd_t1_re", 64'(a_re), 64'd1);
        chk("rd_t1_addr", 64'(a_saddr), 64'd5);
        tick();
        chk("rd_t2_no_rsp", 64'(a_rsp_valid), 64'd0);
        chk("rd_t2_re_low", 64'(a_re), 64'd0);
        tick();
        chk("rd_t3_rsp_valid", 64'(a_rsp_valid), 64'd1);
        tick();

        // Last word of a full 2**ADDR_W array is in range.
        a_rq.push_back({32'hA0A0_003F, 1'b0});
        a_send(2'd0, 6'd63, 32'h0);
        chk("rd63_re", 64'(a_re), 64'd1);
        chk("rd63_addr", 64'(a_saddr), 64'd63);
        tick(); tick();
        chk("rd63_rsp_valid", 64'(a_rsp_valid), 64'd1);
        tick();
        chk("done_sticky", 64'(a_done), 64'd1);

        // Response back-pressure.
        a_rsp_ready = 1'b0;
        a_rq.push_back({32'hA0A0_0007, 1'b0});
        a_send(2'd0, 6'd7, 32'h0);
        tick(); tick();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 32'hA0A0_0007 ||
                a_rsp_err !== 1'b0 || a_req_ready !== 1'b0) bad++;
            tick();
        end
        chk("hold_stable", 64'(bad), 64'd0);
        a_rsp_ready = 1'b1;
        tick();
        chk("hold_release_ready", 64'(a_req_ready), 64'd1);

        // Host-requested preload with response.
        push_a_preload();
        a_rq.push_back({32'h0, 1'b0});
        a_send(2'd2, 6'd0, 32'h0);
        chk("pl_done_cleared", 64'(a_done), 64'd0);
        a_run_preload(1'b1);
        tick();
        chk("pl_rsp_ready", 64'(a_req_ready), 64'd1);

        // Reset in the middle of a preload.
        push_a_preload();
        a_send(2'd2, 6'd0, 32'h0);
        n = 0;
        while (a_init_addr !== 6'd30 && n < 100) begin tick(); n++; end
        chk("pl_reached_30", 64'(a_init_addr), 64'd30);
        rst_n = 1'b0;
        #1;
        chk_reset_outs("reset_async_outs");
        a_wq.delete();
        tick(); tick();
        chk_reset_outs("reset_hold_outs");
        push_a_preload();
        rst_n = 1'b1;
        tick();
        chk("restart_busy", 64'(a_busy), 64'd1);
        a_run_preload(1'b0);

        // Second configuration: DEPTH=16, no automatic preload.
        b_rq.push_back({32'h0, 1'b1});
        b_send(2'd0, 8'd16, 32'h0);
        chk("b_oor_rd_valid", 64'(b_rsp_valid), 64'd1);
        chk("b_oor_rd_err", 64'(b_rsp_err), 64'd1);
        chk("b_oor_rd_strobe", 64'(b_we | b_re), 64'd0);
        tick();
        b_rq.push_back({32'h0, 1'b1});
        b_send(2'd3, 8'd3, 32'h0);
        chk("b_op3_valid", 64'(b_rsp_valid), 64'd1);
        chk("b_op3_strobe", 64'(b_we | b_re), 64'd0);
        tick();
        b_rq.push_back({32'h0, 1'b1});
        b_send(2'd1, 8'd200, 32'h5555_AAAA);
        chk("b_oor_wr_strobe", 64'(b_we | b_re), 64'd0);
        tick();
        b_wq.push_back({8'd15, 32'h1234_5678});
        b_rq.push_back({32'h0, 1'b0});
        b_send(2'd1, 8'd15, 32'h1234_5678);
        chk("b_wr15_we", 64'(b_we), 64'd1);
        tick(); tick();
        b_rq.push_back({32'h1234_5678, 1'b0});
        b_send(2'd0, 8'd15, 32'h0);
        chk("b_rd15_re", 64'(b_re), 64'd1);
        chk("b_rd15_addr", 64'(b_saddr), 64'd15);
        tick(); tick();
        chk("b_rd15_rsp_valid", 64'(b_rsp_valid), 64'd1);
        tick();
        chk("b_never_preloaded", 64'(b_done), 64'd0);

        chk("a_wq_drained", 64'(a_wq.size()), 64'd0);
        chk("a_rq_drained", 64'(a_rq.size()), 64'd0);
        chk("b_wq_drained", 64'(b_wq.size()), 64'd0);
        chk("b_rq_drained", 64'(b_rq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
